pwm_duty_sched: RTL and testbench

PWM_DUTY_SCHED -- requirements
Module: pwm_duty_sched

---
 rtl/pwm_pkg.sv | 32 +++
 rtl/pwm_tick_gen.sv | 60 ++++++
 rtl/pwm_duty_sched.sv | 181 ++++++++++++++++++
 tb/tb_pwm_duty_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared FSM encoding, default constants and the target clamp helper
// for the PWM duty scheduler.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SNAP = 2'd1,
      ST_RAMP = 2'd2,
      ST_HOLD = 2'd3
   } pwm_state_e;

   localparam int PWM_CLK_MHZ_DEF   = 50;
   localparam int PWM_PERIOD_US_DEF = 20000;
   localparam int PWM_STEP_US_DEF   = 10;
   localparam int PWM_MIN_US_DEF    = 1000;
   localparam int PWM_MAX_US_DEF    = 2000;

   function automatic logic [15:0] clamp_us(input logic [15:0] value,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
      logic [15:0] res;
      if (value < lo) begin
         res = lo;
      end else if (value > hi) begin
         res = hi;
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// 1 us tick divider and PWM frame counter; period_start is a registered
// one-cycle pulse after the last tick of each frame.
module pwm_tick_gen #(
   parameter int CLK_VAL_MHZ = 50,
   parameter int PERIOD_US   = 20000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   output logic tick,
   output logic frame_last,
   output logic period_start
);

   localparam int DIV_W = (CLK_VAL_MHZ > 1) ? $clog2(CLK_VAL_MHZ) : 1;
   localparam int FRM_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_VAL_MHZ - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(PERIOD_US - 1);

   logic [DIV_W-1:0] div_cnt_r;
   logic [FRM_W-1:0] frame_cnt_r;
   logic             period_start_r;

   assign tick         = (div_cnt_r == DIV_LAST);
   assign frame_last   = (frame_cnt_r == FRM_LAST);
   assign period_start = period_start_r;

   // Clock divider counting 0..CLK_VAL_MHZ-1.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt_r <= '0;
      end else if (tick) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // Frame counter in us, advancing once per tick and wrapping at the period.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_cnt_r <= '0;
      end else if (tick && frame_last) begin
         frame_cnt_r <= '0;
      end else if (tick) begin
         frame_cnt_r <= frame_cnt_r + FRM_W'(1);
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   // Frame boundary pulse.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         period_start_r <= 1'b0;
      end else begin
         period_start_r <= tick & frame_last;
      end
   end

endmodule

// File: rtl/pwm_duty_sched.sv
// PWM duty scheduler: snaps to the first target, then ramps ctrl_value by at
// most STEP_US per frame. Define PWM_DUTY_CLAMP_EN to clamp targets to [MIN_US, MAX_US].
module pwm_duty_sched
   import pwm_pkg::*;
#(
   parameter int CLK_VAL_MHZ = PWM_CLK_MHZ_DEF,
   parameter int PERIOD_US   = PWM_PERIOD_US_DEF,
   parameter int STEP_US     = PWM_STEP_US_DEF,
   parameter int MIN_US      = PWM_MIN_US_DEF,
   parameter int MAX_US      = PWM_MAX_US_DEF
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        tgt_valid,
   input  logic [15:0] tgt_value,
   output logic        tgt_ready,
   output logic [15:0] ctrl_value,
   output logic        period_start,
   output logic        busy,
   output logic        done
);

`ifdef PWM_DUTY_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   localparam logic [15:0] STEP_W = 16'(STEP_US);
   localparam logic [15:0] MIN_W  = 16'(MIN_US);
   localparam logic [15:0] MAX_W  = 16'(MAX_US);

   pwm_state_e  state_r;
   pwm_state_e  state_nxt_s;
   logic [15:0] ctrl_r;
   logic [15:0] ctrl_nxt_s;
   logic [15:0] tgt_r;
   logic [15:0] tgt_nxt_s;
   logic        done_r;
   logic        done_nxt_s;
   logic        busy_r;
   logic        busy_nxt_s;
   logic        ready_r;
   logic        ready_nxt_s;

   logic        tick_s;
   logic        frame_last_s;
   logic        frame_edge_s;
   logic        accept_s;
   logic [15:0] tgt_in_s;
   logic        ramp_up_s;
   logic [16:0] mag_s;
   logic [15:0] step_s;
   logic [15:0] ramp_val_s;

   pwm_tick_gen #(
      .CLK_VAL_MHZ (CLK_VAL_MHZ),
      .PERIOD_US   (PERIOD_US)
   ) u_tick_gen (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .tick         (tick_s),
      .frame_last   (frame_last_s),
      .period_start (period_start)
   );

   // ctrl_value may only move on the edge that raises period_start.
   assign frame_edge_s = tick_s & frame_last_s;
   assign accept_s     = tgt_valid & ready_r;
   assign tgt_in_s     = CLAMP_EN ? clamp_us(tgt_value, MIN_W, MAX_W) : tgt_value;

   assign tgt_ready  = ready_r;
   assign ctrl_value = ctrl_r;
   assign busy       = busy_r;
   assign done       = done_r;

   // Ramp step: the magnitude is formed in 17 bits so neither direction can wrap.
   always_comb begin
      ramp_up_s = (tgt_r > ctrl_r);
      if (ramp_up_s) begin
         mag_s = {1'b0, tgt_r} - {1'b0, ctrl_r};
      end else begin
         mag_s = {1'b0, ctrl_r} - {1'b0, tgt_r};
      end
      if (mag_s < {1'b0, STEP_W}) begin
         step_s = mag_s[15:0];
      end else begin
         step_s = STEP_W;
      end
      if (ramp_up_s) begin
         ramp_val_s = ctrl_r + step_s;
      end else begin
         ramp_val_s = ctrl_r - step_s;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt_s = state_r;
      ctrl_nxt_s  = ctrl_r;
      tgt_nxt_s   = tgt_r;
      done_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               tgt_nxt_s   = tgt_in_s;
               state_nxt_s = ST_SNAP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SNAP: begin
            if (frame_edge_s) begin
               ctrl_nxt_s  = tgt_r;
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_SNAP;
            end
         end
         ST_RAMP: begin
            if (frame_edge_s) begin
               ctrl_nxt_s = ramp_val_s;
               if (ramp_val_s == tgt_r) begin
                  done_nxt_s  = 1'b1;
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_RAMP;
               end
            end else begin
               state_nxt_s = ST_RAMP;
            end
         end
         ST_HOLD: begin
            if (accept_s) begin
               tgt_nxt_s = tgt_in_s;
               if (tgt_in_s == ctrl_r) begin
                  done_nxt_s  = 1'b1;
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_RAMP;
               end
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      busy_nxt_s  = (state_nxt_s == ST_SNAP) || (state_nxt_s == ST_RAMP);
      ready_nxt_s = ~busy_nxt_s;
   end

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath and registered status outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ctrl_r  <= 16'd0;
         tgt_r   <= 16'd0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         ctrl_r  <= ctrl_nxt_s;
         tgt_r   <= tgt_nxt_s;
         done_r  <= done_nxt_s;
         busy_r  <= busy_nxt_s;
         ready_r <= ready_nxt_s;
      end
   end

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Self-checking bench for pwm_duty_sched: directed scenarios with literal
// expectations plus randomized traffic against a behavioural frame model.
module tb_pwm_duty_sched;

   localparam int CLK_MHZ = 2;
   localparam int PER     = 100;
   localparam int STEP    = 10;
   localparam int MIN_V   = 20;
   localparam int MAX_V   = 80;
   localparam int FRAME   = CLK_MHZ * PER;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        tgt_valid = 1'b0;
   logic [15:0] tgt_value = 16'd0;
   logic        tgt_ready;
   logic [15:0] ctrl_value;
   logic        period_start;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   pwm_duty_sched #(
      .CLK_VAL_MHZ (CLK_MHZ),
      .PERIOD_US   (PER),
      .STEP_US     (STEP),
      .MIN_US      (MIN_V),
      .MAX_US      (MAX_V)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .tgt_valid    (tgt_valid),
      .tgt_value    (tgt_value),
      .tgt_ready    (tgt_ready),
      .ctrl_value   (ctrl_value),
      .period_start (period_start),
      .busy         (busy),
      .done         (done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int model_clamp(input int v);
`ifdef PWM_DUTY_CLAMP_EN
      if (v < MIN_V) return MIN_V;
      if (v > MAX_V) return MAX_V;
`endif
      return v;
   endfunction

   // Behavioural model: edges since reset define frames; a commanded target is
   // applied whole the first time, then approached by at most STEP per frame.
   int m_cyc;
   int m_ctrl;
   int m_tgt;
   bit m_cmd;
   bit m_snap;
   bit m_busy;
   bit m_done;
   bit m_ps;
   bit m_ready;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      int c, t, d, st, n;
      bit cm, sn, bz, dn, bnd;
      if (!sys_rst_n) begin
         m_cyc <= 0; m_ctrl <= 0; m_tgt <= 0; m_cmd <= 1'b0; m_snap <= 1'b0;
         m_busy <= 1'b0; m_done <= 1'b0; m_ps <= 1'b0; m_ready <= 1'b1;
      end else begin
         n = m_cyc + 1;
         c = m_ctrl; t = m_tgt; cm = m_cmd; sn = m_snap; bz = m_busy;
         dn = 1'b0;
         bnd = ((n % FRAME) == 0);
         if (bz) begin
            if (bnd) begin
               if (sn) begin
                  c = t;
               end else begin
                  d  = t - c;
                  st = (d > 0) ? d : -d;
                  if (st > STEP) st = STEP;
                  c = (d > 0) ? c + st : c - st;
               end
               if (c == t) begin
                  dn = 1'b1; bz = 1'b0; sn = 1'b0;
               end
            end
         end else if (tgt_valid && m_ready) begin
            t = model_clamp(int'(tgt_value));
            if (!cm) begin
               cm = 1'b1; sn = 1'b1; bz = 1'b1;
            end else if (t == c) begin
               dn = 1'b1;
            end else begin
               bz = 1'b1;
            end
         end
         m_cyc <= n; m_ctrl <= c; m_tgt <= t; m_cmd <= cm; m_snap <= sn;
         m_busy <= bz; m_done <= dn; m_ps <= bnd; m_ready <= ~bz;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge sys_clk) begin
      if (chk_en) begin
         cmp("ctrl_value",   int'(ctrl_value),   m_ctrl);
         cmp("tgt_ready",    int'(tgt_ready),    int'(m_ready));
         cmp("busy",         int'(busy),         int'(m_busy));
         cmp("done",         int'(done),         int'(m_done));
         cmp("period_start", int'(period_start), int'(m_ps));
      end
   end

   task automatic step_clk();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_ps(output int waited);
      waited = 0;
      do begin
         step_clk();
         waited++;
      end while (!period_start && waited < 2 * FRAME);
      if (!period_start) begin
         n_cmp++;
         n_bad++;
         $display("FAIL period_start_timeout: got none, expected one within %0d cycles", 2 * FRAME);
      end
   endtask

   task automatic command(input int v);
      tgt_valid = 1'b1;
      tgt_value = 16'(v);
      step_clk();
      tgt_valid = 1'b0;
   endtask

   initial begin
      int w;
      int exp_up[3]   = '{60, 70, 75};
      int exp_down[4] = '{65, 55, 45, 40};

      repeat (3) step_clk();
      chk_en = 1'b1;
      cmp("rst_ctrl", int'(ctrl_value), 0);
      cmp("rst_ready", int'(tgt_ready), 1);
      sys_rst_n = 1'b1;
      cmp("idle_busy", int'(busy), 0);
      wait_ps(w);
      cmp("first_ps_gap", w, FRAME);
      wait_ps(w);
      cmp("ps_period", w, FRAME);

      // First command snaps at the next frame boundary.
      command(50);
      cmp("snap_busy", int'(busy), 1);
      cmp("snap_ready", int'(tgt_ready), 0);
      wait_ps(w);
      cmp("snap_ctrl", int'(ctrl_value), 50);
      cmp("snap_done", int'(done), 1);
      step_clk();
      cmp("hold_ready", int'(tgt_ready), 1);
      cmp("hold_busy", int'(busy), 0);

      // Ramp up with a competing target held on the input throughout.
      tgt_valid = 1'b1;
      tgt_value = 16'd75;
      step_clk();
      tgt_value = 16'd40;
      cmp("ramp_busy", int'(busy), 1);
      for (int i = 0; i < 3; i++) begin
         wait_ps(w);
         cmp("ramp_up_ctrl", int'(ctrl_value), exp_up[i]);
         cmp("ramp_up_done", int'(done), (i == 2) ? 1 : 0);
         cmp("ramp_up_ready", int'(tgt_ready), (i == 2) ? 1 : 0);
      end
      step_clk();
      tgt_valid = 1'b0;
      cmp("held_accept_busy", int'(busy), 1);
      for (int i = 0; i < 4; i++) begin
         wait_ps(w);
         cmp("ramp_dn_ctrl", int'(ctrl_value), exp_down[i]);
         cmp("ramp_dn_done", int'(done), (i == 3) ? 1 : 0);
      end

      // Out-of-range target.
      command(95);
      for (int k = 0; k < 12; k++) begin
         if (!done) wait_ps(w);
      end
`ifdef PWM_DUTY_CLAMP_EN
      cmp("clamp_final", int'(ctrl_value), 80);
`else
      cmp("noclamp_final", int'(ctrl_value), 95);
`endif

      // Reset in the middle of a ramp.
      sys_rst_n = 1'b0;
      step_clk();
      sys_rst_n = 1'b1;
      command(50);
      wait_ps(w);
      command(75);
      wait_ps(w);
      cmp("pre_rst_ctrl", int'(ctrl_value), 60);
      repeat (50) step_clk();
      #2;
      sys_rst_n = 1'b0;
      #1;
      cmp("mid_rst_ctrl", int'(ctrl_value), 0);
      cmp("mid_rst_ready", int'(tgt_ready), 1);
      cmp("mid_rst_busy", int'(busy), 0);
      step_clk();
      sys_rst_n = 1'b1;
      command(30);
      cmp("post_rst_snap_busy", int'(busy), 1);
      wait_ps(w);
      cmp("post_rst_ps_gap", w, FRAME - 1);
      cmp("post_rst_ctrl", int'(ctrl_value), 30);
      cmp("post_rst_done", int'(done), 1);

      // Equal target in HOLD.
      step_clk();
      command(30);
      cmp("eq_done", int'(done), 1);
      cmp("eq_busy", int'(busy), 0);
      cmp("eq_ctrl", int'(ctrl_value), 30);
      step_clk();
      cmp("eq_done_clear", int'(done), 0);

      // Accept on the frame-boundary edge takes effect one frame later.
      wait_ps(w);
      repeat (FRAME - 1) step_clk();
      tgt_valid = 1'b1;
      tgt_value = 16'd50;
      step_clk();
      tgt_valid = 1'b0;
      cmp("bnd_ps", int'(period_start), 1);
      cmp("bnd_ctrl", int'(ctrl_value), 30);
      cmp("bnd_busy", int'(busy), 1);
      wait_ps(w);
      cmp("bnd_gap", w, FRAME);
      cmp("bnd_ctrl_next", int'(ctrl_value), 40);

      // Randomized traffic.
      for (int i = 0; i < 50000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         tgt_valid = (r < 4);
         r = $urandom_range(0, 9);
         if (r < 2) begin
            tgt_value = 16'(m_ctrl);
         end else if (r < 4) begin
            tgt_value = 16'(m_ctrl + $urandom_range(0, 25));
         end else begin
            tgt_value = 16'($urandom_range(0, 130));
         end
         if ($urandom_range(0, 7999) == 0) begin
            sys_rst_n = 1'b0;
            #2;
            sys_rst_n = 1'b1;
         end
         step_clk();
      end
      tgt_valid = 1'b0;
      step_clk();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
